// File: rtl/imm_encoder.sv
// Packs a 64-bit immediate into the immediate field of a LEGv8 instruction word.
// Wide immediates (IW) expand into a MOVZ/MOVK sequence emitted one word per handshake.
module imm_encoder (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  InCtrl,
    input  logic [63:0] InValue,
    input  logic [31:0] InTemplate,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic        OutLast,
    output logic        OutErr
);

    localparam logic [2:0] CTRL_I  = 3'b000;
    localparam logic [2:0] CTRL_D  = 3'b001;
    localparam logic [2:0] CTRL_CB = 3'b010;
    localparam logic [2:0] CTRL_B  = 3'b011;
    localparam logic [2:0] CTRL_IW = 3'b100;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [2:0]  ctrl_q;
    logic [63:0] value_q;
    logic [31:0] tmpl_q;
    logic [1:0]  hw_q;

    function automatic logic [3:0] nz_halves(input logic [63:0] v);
        return {v[63:48] != '0, v[47:32] != '0, v[31:16] != '0, v[15:0] != '0};
    endfunction

    // Lowest set halfword index; an all-zero mask maps to hw 0 (MOVZ #0).
    function automatic logic [1:0] lowest(input logic [3:0] m);
        casez (m)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] above(input logic [3:0] nz, input logic [1:0] hw);
        logic [3:0] m;
        m = 4'b1110 << hw;
        return nz & m;
    endfunction

    function automatic logic [31:0] iw_word(input logic [63:0] v, input logic [31:0] t,
                                            input logic [1:0] hw, input logic movk);
        logic [31:0] w;
        w        = t & ~32'h007F_FFE0;
        w[22:21] = hw;
        w[20:5]  = v[{hw, 4'b0000} +: 16];
        if (movk)
            w[29] = 1'b1;
        return w;
    endfunction

    logic [31:0] acc_instr, acc_mask, acc_field;
    logic        acc_last, acc_err, acc_fits;
    logic [1:0]  acc_hw;
    logic [3:0]  in_nz;

    always_comb begin
        acc_mask  = '0;
        acc_field = '0;
        acc_fits  = 1'b1;
        acc_hw    = '0;
        acc_last  = 1'b1;
        acc_err   = 1'b0;
        in_nz     = nz_halves(InValue);
        acc_instr = InTemplate;
        case (InCtrl)
            CTRL_I: begin
                acc_mask  = 32'h003F_FC00;
                acc_field = {10'b0, InValue[11:0], 10'b0};
                acc_fits  = InValue[63:12] == '0;
            end
            CTRL_D: begin
                acc_mask  = 32'h001F_F000;
                acc_field = {11'b0, InValue[8:0], 12'b0};
                acc_fits  = InValue[63:8] == {56{InValue[8]}};
            end
            CTRL_CB: begin
                acc_mask  = 32'h00FF_FFE0;
                acc_field = {8'b0, InValue[18:0], 5'b0};
                acc_fits  = InValue[63:18] == {46{InValue[18]}};
            end
            CTRL_B: begin
                acc_mask  = 32'h03FF_FFFF;
                acc_field = {6'b0, InValue[25:0]};
                acc_fits  = InValue[63:25] == {39{InValue[25]}};
            end
            CTRL_IW: begin
                acc_hw   = lowest(in_nz);
                acc_last = ~|above(in_nz, acc_hw);
            end
            default: acc_fits = 1'b0;
        endcase
        if (InCtrl == CTRL_IW)
            acc_instr = iw_word(InValue, InTemplate, acc_hw, 1'b0);
        else if (acc_fits)
            acc_instr = (InTemplate & ~acc_mask) | acc_field;
        else
            acc_err = 1'b1;
    end

    logic [3:0]  q_nz, q_above;
    logic [1:0]  nx_hw;
    logic [31:0] nx_instr;
    logic        nx_last;

    always_comb begin
        q_nz     = nz_halves(value_q);
        q_above  = above(q_nz, hw_q);
        nx_hw    = lowest(q_above);
        nx_instr = iw_word(value_q, tmpl_q, nx_hw, 1'b1);
        nx_last  = ~|above(q_nz, nx_hw);
    end

    always_comb InReady = (state == IDLE);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            ctrl_q   <= '0;
            value_q  <= '0;
            tmpl_q   <= '0;
            hw_q     <= '0;
            OutValid <= 1'b0;
            OutInstr <= '0;
            OutLast  <= 1'b0;
            OutErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        ctrl_q   <= InCtrl;
                        value_q  <= InValue;
                        tmpl_q   <= InTemplate;
                        hw_q     <= acc_hw;
                        OutValid <= 1'b1;
                        OutInstr <= acc_instr;
                        OutLast  <= acc_last;
                        OutErr   <= acc_err;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (OutReady) begin
                        if (OutLast || ctrl_q != CTRL_IW) begin
                            OutValid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            hw_q     <= nx_hw;
                            OutInstr <= nx_instr;
                            OutLast  <= nx_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes hand-computed words, a negedge
// monitor pops and compares each word as it is handed off.
module tb_imm_encoder;

    logic        CLK = 1'b0;
    logic        Reset, InValid, InReady, OutValid, OutReady, OutLast, OutErr;
    logic [2:0]  InCtrl;
    logic [63:0] InValue;
    logic [31:0] InTemplate, OutInstr;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    imm_encoder dut (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InCtrl(InCtrl), .InValue(InValue), .InTemplate(InTemplate),
        .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr),
        .OutLast(OutLast), .OutErr(OutErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (!Reset && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", OutInstr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_instr", OutInstr, e.instr);
                check("word_last", {31'b0, OutLast}, {31'b0, e.last});
                check("word_err", {31'b0, OutErr}, {31'b0, e.err});
            end
        end
    end

    task automatic expect_word(input logic [31:0] instr, input logic last, input logic err);
        exp_t e;
        e.instr = instr;
        e.last  = last;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] c, input logic [63:0] v, input logic [31:0] t);
        int unsigned n;
        n = 0;
        while (!InReady && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!InReady) begin
            check("accept_timeout", 32'(InReady), 32'd1);
        end else begin
            InCtrl     = c;
            InValue    = v;
            InTemplate = t;
            InValid    = 1'b1;
            @(posedge CLK); #1;
            InValid    = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || !InReady) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb.size() != 0 || !InReady) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        InCtrl = '0; InValue = '0; InTemplate = '0;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        check("rst_outvalid", {31'b0, OutValid}, 32'd0);
        check("rst_outinstr", OutInstr, 32'd0);
        check("rst_outlast", {31'b0, OutLast}, 32'd0);
        check("rst_outerr", {31'b0, OutErr}, 32'd0);
        check("rst_inready", {31'b0, InReady}, 32'd1);

        expect_word(32'h9104_8C00, 1'b1, 1'b0); send(3'b000, 64'h123, 32'h9100_0000); drain();
        expect_word(32'h9100_0000, 1'b1, 1'b1); send(3'b000, 64'h1000, 32'h9100_0000); drain();
        expect_word(32'hF85F_8000, 1'b1, 1'b0); send(3'b001, -64'sd8, 32'hF840_0000); drain();
        expect_word(32'hF850_0000, 1'b1, 1'b0); send(3'b001, -64'sd256, 32'hF840_0000); drain();
        expect_word(32'hF840_0000, 1'b1, 1'b1); send(3'b001, 64'd256, 32'hF840_0000); drain();
        expect_word(32'hB4FF_FFE0, 1'b1, 1'b0); send(3'b010, -64'sd1, 32'hB400_0000); drain();
        expect_word(32'h1400_0000, 1'b1, 1'b1); send(3'b011, 64'h200_0000, 32'h1400_0000); drain();
        expect_word(32'h1600_0000, 1'b1, 1'b0); send(3'b011, -64'sh200_0000, 32'h1400_0000); drain();
        expect_word(32'hABCD_1234, 1'b1, 1'b1); send(3'b101, 64'h5, 32'hABCD_1234); drain();

        expect_word(32'hD295_79A9, 1'b0, 1'b0);
        expect_word(32'hF2E0_0029, 1'b1, 1'b0);
        send(3'b100, 64'h0001_0000_0000_ABCD, 32'hD280_0009); drain();

        // hw0 and hw2 populated, hw1 skipped
        expect_word(32'hD280_0049, 1'b0, 1'b0);
        expect_word(32'hF2C0_0029, 1'b1, 1'b0);
        send(3'b100, 64'h0000_0001_0000_0002, 32'hD280_0009); drain();

        expect_word(32'hD2C2_4689, 1'b1, 1'b0);
        send(3'b100, 64'h0000_1234_0000_0000, 32'hD280_0009); drain();

        // IW zero with backpressure; a request offered during EMIT must be ignored
        OutReady = 1'b0;
        expect_word(32'hD280_0009, 1'b1, 1'b0);
        send(3'b100, 64'h0, 32'hD280_0009);
        InCtrl = 3'b000; InValue = 64'h5; InTemplate = 32'h9100_0000; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_outvalid", {31'b0, OutValid}, 32'd1);
            check("bp_instr", OutInstr, 32'hD280_0009);
            check("bp_last", {31'b0, OutLast}, 32'd1);
            check("bp_inready", {31'b0, InReady}, 32'd0);
            @(posedge CLK); #1;
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        drain();
        repeat (3) @(posedge CLK);
        #1 check("bp_no_extra", {31'b0, OutValid}, 32'd0);

        // Reset while the second word of an all-ones IW sequence is pending
        expect_word(32'hD29F_FFE9, 1'b0, 1'b0);
        send(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 32'hD280_0009);
        @(posedge CLK); #1;
        OutReady = 1'b0;
        check("iw_second_word", OutInstr, 32'hF2BF_FFE9);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        check("midrst_outvalid", {31'b0, OutValid}, 32'd0);
        check("midrst_inready", {31'b0, InReady}, 32'd1);
        OutReady = 1'b1;
        expect_word(32'h9104_8C00, 1'b1, 1'b0); send(3'b000, 64'h123, 32'h9100_0000); drain();

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
